// File: rtl/bpsk_frame_transmitter_if.sv
// Payload handshake between the framing logic (master) and the BPSK frame transmitter (slave).
// A word transfers on a rising clock edge where payload_valid && payload_ready are both high.
// A payload_valid seen while payload_ready is low is ignored: nothing is captured or queued.
interface bpsk_frame_transmitter_if #(
    parameter int PAYLOAD_WIDTH = 16
);
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic                     payload_valid;
    logic                     payload_ready;

    modport master (
        output payload,
        output payload_valid,
        input  payload_ready
    );

    modport slave (
        input  payload,
        input  payload_valid,
        output payload_ready
    );
endinterface

// File: rtl/bpsk_frame_transmitter.sv
// BPSK frame transmitter: preamble bits, then payload bits, as carrier periods
// on an unsigned AMPLITUDE-offset sample stream, followed by an idle guard gap.
module bpsk_frame_transmitter #(
    parameter int                         DATA_WIDTH      = 8,
    parameter int                         WAVELENGTH      = 4,
    parameter int                         AMPLITUDE       = 100,
    parameter int                         PREAMBLE_LENGTH = 8,
    parameter logic [PREAMBLE_LENGTH-1:0] PREAMBLE        = 8'b10110010,
    parameter int                         PAYLOAD_WIDTH   = 16,
    parameter int                         GUARD_CYCLES    = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    bpsk_frame_transmitter_if.slave        tx_if,
    output logic [DATA_WIDTH-1:0]          signal_out,
    output logic                           tx_active,
    output logic                           done,
    output logic [1:0]                     state_dbg
);

    localparam int  TOTAL_BITS = PREAMBLE_LENGTH + PAYLOAD_WIDTH;
    localparam int  PHASE_W    = (WAVELENGTH > 1) ? $clog2(WAVELENGTH) : 1;
    localparam int  BIT_W      = $clog2(TOTAL_BITS + 1);
    localparam int  GUARD_W    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam real PI         = 3.14159265358979323846;
    localparam logic [DATA_WIDTH-1:0] IDLE_LEVEL = DATA_WIDTH'(AMPLITUDE);

    if (2 * AMPLITUDE > (2 ** DATA_WIDTH) - 1) begin : g_amplitude_check
        $error("AMPLITUDE too large: 2*AMPLITUDE must fit in DATA_WIDTH bits");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    // Carrier sample k: AMPLITUDE + round(AMPLITUDE * sin(2*pi*k/WAVELENGTH)).
    function automatic logic [DATA_WIDTH-1:0] carrier(input int k);
        real s;
        int  r;
        s = real'(AMPLITUDE) * $sin(2.0 * PI * real'(k) / real'(WAVELENGTH));
        r = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
        return DATA_WIDTH'(AMPLITUDE + r);
    endfunction

    // A zero bit mirrors the carrier about midscale (180-degree flip).
    function automatic logic [DATA_WIDTH-1:0] bpsk_map(input logic                  bit_val,
                                                       input logic [DATA_WIDTH-1:0] carrier_s);
        logic [DATA_WIDTH:0] flipped;
        flipped = (DATA_WIDTH + 1)'(2 * AMPLITUDE) - {1'b0, carrier_s};
        return bit_val ? carrier_s : flipped[DATA_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] lut [WAVELENGTH];

    for (genvar k = 0; k < WAVELENGTH; k++) begin : g_lut
        assign lut[k] = carrier(k);
    end

    state_t                  state, state_n;
    logic [TOTAL_BITS-1:0]   shreg, shreg_n;
    logic [PHASE_W-1:0]      phase, phase_n;
    logic [BIT_W-1:0]        bit_cnt, bit_cnt_n;
    logic [GUARD_W-1:0]      guard_cnt, guard_cnt_n;
    logic [DATA_WIDTH-1:0]   signal_n;
    logic                    tx_active_n;
    logic                    done_n;
    logic                    handshake;
    logic                    last_phase;
    logic                    last_bit;
    logic                    last_guard;

    assign tx_if.payload_ready = (state == S_IDLE);
    assign handshake           = tx_if.payload_valid && tx_if.payload_ready;
    assign last_phase          = (phase == PHASE_W'(WAVELENGTH - 1));
    assign last_bit            = (bit_cnt == BIT_W'(TOTAL_BITS - 1));
    assign last_guard          = (guard_cnt == GUARD_W'(GUARD_CYCLES - 1));
    assign state_dbg           = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            shreg      <= '0;
            phase      <= '0;
            bit_cnt    <= '0;
            guard_cnt  <= '0;
            signal_out <= IDLE_LEVEL;
            tx_active  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            phase      <= phase_n;
            bit_cnt    <= bit_cnt_n;
            guard_cnt  <= guard_cnt_n;
            signal_out <= signal_n;
            tx_active  <= tx_active_n;
            done       <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        phase_n     = phase;
        bit_cnt_n   = bit_cnt;
        guard_cnt_n = guard_cnt;
        done_n      = 1'b0;

        case (state)
            S_IDLE: begin
                if (handshake) begin
                    state_n   = S_SEND;
                    shreg_n   = {PREAMBLE, tx_if.payload};
                    phase_n   = '0;
                    bit_cnt_n = '0;
                end
            end
            S_SEND: begin
                if (last_phase) begin
                    phase_n   = '0;
                    shreg_n   = shreg << 1;
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (last_bit) begin
                        guard_cnt_n = '0;
                        if (GUARD_CYCLES == 0) begin
                            state_n = S_IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = S_GUARD;
                        end
                    end
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            S_GUARD: begin
                if (last_guard) begin
                    state_n     = S_IDLE;
                    guard_cnt_n = '0;
                    done_n      = 1'b1;
                end else begin
                    guard_cnt_n = guard_cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // The output register is loaded from the next-state view so the first
        // sample appears on the cycle right after the handshake.
        if (state_n == S_SEND) begin
            signal_n = bpsk_map(shreg_n[TOTAL_BITS-1], lut[phase_n]);
        end else begin
            signal_n = IDLE_LEVEL;
        end
        tx_active_n = (state_n == S_SEND);
    end

endmodule
